// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter: state encoding,
// port identifiers, default memory depth and the access error check.
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEPTH_WORDS_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  // Word index is compared at its full 30-bit width so large addresses never alias low words.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: under contention the port that did not win
// last gets the grant; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core LSU (port 0) and the
// debug/DMA loader (port 1); one single-cycle access in flight at a time.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [63:0]         req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_read_en,
  output logic                mem_write_en,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  // Handshake: a request on port i transfers on a rising clk edge where
  // req_valid[i] & req_ready[i]; unserved ports hold their request stable.

  logic [1:0]        state_q;
  logic              last_grant_q;
  logic              id_q;
  logic              write_q;
  logic              err_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        grant;
  logic              sel;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              handshake;
  logic              in_idle;
  logic              in_access;
  logic              in_resp;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Reset gates every output so a write landing on a reset edge never commits.
  assign in_idle   = (state_q == ST_IDLE)   && !reset;
  assign in_access = (state_q == ST_ACCESS) && !reset;
  assign in_resp   = (state_q == ST_RESP)   && !reset;

  assign req_ready = in_idle ? (grant & req_valid) : 2'b00;
  assign handshake = |req_ready;

  assign sel       = grant[PORT_DBG];
  assign sel_write = sel ? req_write[PORT_DBG] : req_write[PORT_CORE];
  assign sel_addr  = sel ? req_addr[63:32] : req_addr[31:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            id_q         <= sel;
            write_q      <= sel_write;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            err_q        <= addr_err(sel_addr, DEPTH_WORDS);
            last_grant_q <= sel;
            rdata_q      <= '0;
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= mem_read_en ? mem_rdata : '0;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          rdata_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read_en  = in_access && !err_q && !write_q;
  assign mem_write_en = in_access && !err_q && write_q;
  assign mem_addr     = in_access ? addr_q : 32'd0;
  assign mem_wdata    = in_access ? wdata_q : '0;

  always_comb begin
    rsp_valid            = 2'b00;
    rsp_valid[PORT_CORE] = in_resp && !id_q;
    rsp_valid[PORT_DBG]  = in_resp && id_q;
  end

  assign rsp_rdata = in_resp ? rdata_q : '0;
  assign rsp_err   = in_resp && err_q;
  assign dbg_state = state_q;

endmodule
